// File: rtl/axil_pkg.sv
// axil_pkg: shared response codes, B-channel states and address helpers
package axil_pkg;
  typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} axil_resp_e;
  typedef enum logic {IDLE, RESP} axil_bstate_e;
  function automatic int axil_addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction
endpackage

// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI-Lite write-path bundle (AW, W, B channels)
// slave modport drives awready/wready/bresp/bvalid; master drives the rest.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axil_hold_slot.sv
// axil_hold_slot: one-deep valid/ready holding register
// in_valid/in_data/in_ready: upstream handshake; clr: drop contents;
// full/data: slot state. in_ready comes straight from the full flop.
module axil_hold_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr,
  output logic             in_ready,
  output logic             full,
  output logic [WIDTH-1:0] data
);
  logic             full_q, full_d, take;
  logic [WIDTH-1:0] data_q, data_d;
  always_comb begin
    take   = in_valid && !full_q;
    full_d = take || (full_q && !clr);
    data_d = take ? in_data : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end
  assign in_ready = !full_q;
  assign full     = full_q;
  assign data     = data_q;
endmodule

// File: rtl/axil_write_slave.sv
// axil_write_slave: AXI-Lite write responder backed by a byte-strobed register bank
// clk/rst_n (async, active-low); axi_bus: axi_lite_if.slave;
// regs_o: flat bank, reg i at [i*DATA_WIDTH +: DATA_WIDTH]; wr_pulse_o: one-hot write strobe.
// AXIL_WSLV_RANGE_CHECK_EN: out-of-range index gives SLVERR instead of modulo decode.
module axil_write_slave
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  axi_lite_if.slave                      axi_bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = axil_addr_lsb(DATA_WIDTH);
  localparam int IDX_W    = $clog2(NUM_REGS);
  logic                  aw_full, w_full, aw_ready, w_ready, commit, in_range;
  logic [ADDR_WIDTH-1:0] aw_addr, sel;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic [NUM_REGS-1:0]   wr_pulse_d, wr_pulse_q;
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  axil_resp_e            resp, bresp_d, bresp_q;
  axil_bstate_e          state_d, state_q;
  axil_hold_slot #(.WIDTH(ADDR_WIDTH)) u_aw (
    .clk(clk), .rst_n(rst_n), .in_valid(axi_bus.awvalid), .in_data(axi_bus.awaddr),
    .clr(commit), .in_ready(aw_ready), .full(aw_full), .data(aw_addr)
  );
  axil_hold_slot #(.WIDTH(DATA_WIDTH + STRB_W)) u_w (
    .clk(clk), .rst_n(rst_n), .in_valid(axi_bus.wvalid), .in_data({axi_bus.wstrb, axi_bus.wdata}),
    .clr(commit), .in_ready(w_ready), .full(w_full), .data({w_strb, w_data})
  );
  always_comb begin
    // A pending response may retire in the same cycle a new one is committed.
    commit = aw_full && w_full && (state_q == IDLE || axi_bus.bready);
`ifdef AXIL_WSLV_RANGE_CHECK_EN
    sel      = aw_addr >> ADDR_LSB;
    in_range = sel < ADDR_WIDTH'(NUM_REGS);
    resp     = in_range ? OKAY : SLVERR;
`else
    sel      = (aw_addr >> ADDR_LSB) & ADDR_WIDTH'((1 << IDX_W) - 1);
    in_range = sel < ADDR_WIDTH'(NUM_REGS);
    resp     = OKAY;
`endif
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_pulse_d[i] = commit && in_range && sel == ADDR_WIDTH'(i);
      regs_d[i]     = regs_q[i];
      for (int k = 0; k < STRB_W; k++)
        regs_d[i][8*k +: 8] = (wr_pulse_d[i] && w_strb[k]) ? w_data[8*k +: 8] : regs_q[i][8*k +: 8];
    end
    bresp_d = commit ? resp : bresp_q;
    state_d = commit ? RESP : (axi_bus.bready ? IDLE : state_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bresp_q    <= OKAY;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end
  assign wr_pulse_o      = wr_pulse_q;
  assign axi_bus.awready = aw_ready;
  assign axi_bus.wready  = w_ready;
  assign axi_bus.bvalid  = state_q == RESP;
  assign axi_bus.bresp   = bresp_q;
endmodule
